mem_port_arbiter: RTL and testbench

- Two-requester controller in front of the 512x8 byte-addressed RAM: instruction-fetch port (word reads only) and data port (byte/halfword/word read or write).
- Arbitrates, registers one request, drives the RAM's memFuncActive/memFuncComplete handshake, captures and zero-extends read data, and returns a one-cycle done pulse to the winner.
- Also rejects misaligned or invalid-size data accesses and times out a stalled RAM.
- Sits between the CPU control unit/fetch logic and the RAM; at most one RAM operation in flight.

---
 rtl/mem_port_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Two-port (fetch / data) front end for a 512x8 byte RAM.
//               It grants one requester and registers that request onto the
//               RAM handshake. It captures read data and zero-extends it to
//               32 bits, and it returns a one-cycle done pulse to the winner.
//               Misaligned or invalid-size accesses are rejected before the
//               RAM is touched. A stalled RAM is abandoned after
//               TIMEOUT_CYCLES cycles.
// Options     : ARB_ROUND_ROBIN_EN - when defined, simultaneous requests
//               alternate between the ports. When undefined, the data port
//               has fixed priority over fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W         = 9,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              Clk,
  input  logic              Reset,
  // instruction-fetch port
  input  logic              ifReq,
  input  logic [ADDR_W-1:0] ifAddress,
  output logic              ifDone,
  output logic              ifError,
  output logic [31:0]       ifData,
  // data port
  input  logic              dReq,
  input  logic              dReadWrite,
  input  logic [ADDR_W-1:0] dAddress,
  input  logic [31:0]       dDataIn,
  input  logic [1:0]        dDataSize,
  output logic              dDone,
  output logic              dError,
  output logic [31:0]       dDataOut,
  // RAM handshake
  output logic              memFuncActive,
  output logic              memReadWrite,
  output logic [ADDR_W-1:0] memAddress,
  output logic [31:0]       memDataIn,
  output logic [1:0]        memDataSize,
  input  logic [31:0]       memDataOut,
  input  logic              memFuncComplete,
  output logic              busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                active_q, active_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          size_q, size_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                win_data_q, win_data_d;  // 1: current op belongs to the data port
  logic                err_q, err_d;
  logic [31:0]         if_data_q, if_data_d;
  logic [31:0]         d_data_q, d_data_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic                rr_last_q, rr_last_d;    // 1: data port was granted last
`endif

  logic                grant_data;
  logic                d_bad;
  logic                if_bad;
  logic [CNT_W-1:0]    cnt_inc;
  logic [31:0]         rd_fmt;

  // Grant selection and request legality checks for the IDLE cycle.
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    grant_data = dReq && (!ifReq || !rr_last_q);
`else
    grant_data = dReq;
`endif
    d_bad  = (dDataSize == 2'b10) ||
             ((dDataSize == 2'b11) && (dAddress[1:0] != 2'b00)) ||
             ((dDataSize == 2'b01) && dAddress[0]);
    if_bad = (ifAddress[1:0] != 2'b00);
    cnt_inc = cnt_q + CNT_W'(1);
  end

  // Zero-extend RAM read data by access size so stale upper bytes never leak.
  always_comb begin
    rd_fmt = memDataOut;
    case (size_q)
      2'b00:   rd_fmt = {24'b0, memDataOut[7:0]};
      2'b01:   rd_fmt = {16'b0, memDataOut[15:0]};
      default: rd_fmt = memDataOut;
    endcase
  end

  // Next-state logic: IDLE grants, ACTIVE waits for completion or timeout, and DONE pulses.
  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    cnt_d      = cnt_q;
    win_data_d = win_data_q;
    err_d      = err_q;
    if_data_d  = if_data_q;
    d_data_d   = d_data_q;
`ifdef ARB_ROUND_ROBIN_EN
    rr_last_d  = rr_last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (ifReq || dReq) begin
          win_data_d = grant_data;
          cnt_d      = '0;
`ifdef ARB_ROUND_ROBIN_EN
          rr_last_d  = grant_data;
`endif
          if (grant_data) begin
            addr_d  = dAddress;
            size_d  = dDataSize;
            rw_d    = dReadWrite;
            wdata_d = dDataIn;
          end else begin
            addr_d  = ifAddress;
            size_d  = 2'b11;
            rw_d    = 1'b0;
            wdata_d = '0;
          end
          if (grant_data ? d_bad : if_bad) begin
            // Rejected: the RAM is never activated.
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d    = 1'b0;
            active_d = 1'b1;
            state_d  = S_ACTIVE;
          end
        end
      end
      S_ACTIVE: begin
        if (memFuncComplete) begin
          active_d = 1'b0;
          err_d    = 1'b0;
          state_d  = S_DONE;
          if (!rw_q) begin
            if (win_data_q) d_data_d  = rd_fmt;
            else            if_data_d = memDataOut;
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_VAL) begin
            active_d = 1'b0;
            err_d    = 1'b1;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        // Active is already low here, so the next op gives the RAM a fresh rising edge.
        active_d = 1'b0;
        cnt_d    = '0;
        state_d  = S_IDLE;
      end
      default: begin
        active_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      active_q   <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      cnt_q      <= '0;
      win_data_q <= 1'b0;
      err_q      <= 1'b0;
      if_data_q  <= '0;
      d_data_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      cnt_q      <= cnt_d;
      win_data_q <= win_data_d;
      err_q      <= err_d;
      if_data_q  <= if_data_d;
      d_data_q   <= d_data_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_q  <= rr_last_d;
`endif
    end
  end

  // Output decode: done/error are qualified by the DONE state and the winner.
  always_comb begin
    ifDone        = (state_q == S_DONE) && !win_data_q;
    dDone         = (state_q == S_DONE) &&  win_data_q;
    ifError       = ifDone && err_q;
    dError        = dDone  && err_q;
    ifData        = if_data_q;
    dDataOut      = d_data_q;
    memFuncActive = active_q;
    memReadWrite  = rw_q;
    memAddress    = addr_q;
    memDataIn     = wdata_q;
    memDataSize   = size_q;
    busy          = (state_q != S_IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. It contains a
//               byte-array RAM model with programmable latency and stall. A
//               transaction-level reference model predicts each done pulse:
//               winner, cycle, error flag and returned data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
  localparam int ADDR_W = 9;
  localparam int TO     = 15;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ifReq, dReq, dReadWrite;
  logic [8:0]  ifAddress, dAddress;
  logic [31:0] dDataIn;
  logic [1:0]  dDataSize;
  logic        ifDone, ifError, dDone, dError;
  logic [31:0] ifData, dDataOut;
  logic        memFuncActive, memReadWrite, memFuncComplete, busy;
  logic [8:0]  memAddress;
  logic [31:0] memDataIn, memDataOut;
  logic [1:0]  memDataSize;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
    .Clk(Clk), .Reset(Reset),
    .ifReq(ifReq), .ifAddress(ifAddress), .ifDone(ifDone), .ifError(ifError), .ifData(ifData),
    .dReq(dReq), .dReadWrite(dReadWrite), .dAddress(dAddress), .dDataIn(dDataIn),
    .dDataSize(dDataSize), .dDone(dDone), .dError(dError), .dDataOut(dDataOut),
    .memFuncActive(memFuncActive), .memReadWrite(memReadWrite), .memAddress(memAddress),
    .memDataIn(memDataIn), .memDataSize(memDataSize), .memDataOut(memDataOut),
    .memFuncComplete(memFuncComplete), .busy(busy)
  );

  always #5 Clk = ~Clk;

  // ---------------- RAM model (environment) ----------------
  logic [7:0] ram [0:511];
  logic       ram_loaded;
  int         ram_cnt;
  int         ram_lat   = 0;
  bit         ram_stall = 1'b0;
  logic [8:0] a1, a2, a3;
  assign a1 = memAddress + 9'd1;
  assign a2 = memAddress + 9'd2;
  assign a3 = memAddress + 9'd3;
  // The model always returns all four bytes, so the DUT must discard the stale upper ones.
  assign memDataOut      = {ram[a3], ram[a2], ram[a1], ram[memAddress]};
  assign memFuncComplete = memFuncActive && !ram_stall && (ram_cnt >= ram_lat);

  always @(posedge Clk) begin
    if (ram_loaded !== 1'b1) begin
      for (int i = 0; i < 512; i++) ram[i] <= 8'h00;
      ram[0] <= 8'h21; ram[1] <= 8'h08; ram[2]  <= 8'h00; ram[3]  <= 8'h00;
      ram[4] <= 8'h21; ram[5] <= 8'h10; ram[6]  <= 8'h21; ram[7]  <= 8'h00;
      ram[8] <= 8'h0F; ram[9] <= 8'h00; ram[10] <= 8'h23; ram[11] <= 8'h24;
      ram_loaded <= 1'b1;
    end else if (memFuncActive && memFuncComplete && memReadWrite) begin
      ram[memAddress] <= memDataIn[7:0];
      if (memDataSize != 2'b00) ram[a1] <= memDataIn[15:8];
      if (memDataSize == 2'b11) begin
        ram[a2] <= memDataIn[23:16];
        ram[a3] <= memDataIn[31:24];
      end
    end
    ram_cnt <= memFuncActive ? ram_cnt + 1 : 0;
  end

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem [0:511];
  logic [31:0] exp_if, exp_d;
`ifdef ARB_ROUND_ROBIN_EN
  bit          rr_last;   // 1: data granted last
`endif
  logic [8:0]  t_fa, t_da;
  logic [1:0]  t_dsz;
  logic        t_drw;
  logic [31:0] t_dwd;
  int          t_lat;
  bit          t_stall;

  function automatic bit d_err(input logic [8:0] a, input logic [1:0] s);
    return (s == 2'b10) || (s == 2'b11 && a[1:0] != 2'b00) || (s == 2'b01 && a[0]);
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_read(input logic [8:0] a, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = ref_mem[9'(int'(a) + i)];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setv(input logic [8:0] fa, input logic [8:0] da, input logic [1:0] dsz,
                      input logic drw, input logic [31:0] dwd, input int lat, input bit stl);
    t_fa = fa; t_da = da; t_dsz = dsz; t_drw = drw; t_dwd = dwd; t_lat = lat; t_stall = stl;
  endtask

  // Wait for one port's done pulse; base = idle cycles before this op can be sampled.
  task automatic serve(input bit isD, input int base);
    bit err, ferr, seen;
    int exp_c, c;
    err   = isD ? d_err(t_da, t_dsz) : (t_fa[1:0] != 2'b00);
    ferr  = err || t_stall;
    exp_c = err ? base + 1 : (t_stall ? base + TO + 1 : base + t_lat + 2);
    c = 0;
    seen = 1'b0;
    while (!seen && c < base + 60) begin
      @(negedge Clk);
      c++;
      if (ifDone || dDone) seen = 1'b1;
      else if (!err && c > base) begin
        chk("active_high", 32'(memFuncActive), 32'd1);
        if (c == base + 1) begin
          chk("mem_addr", 32'(memAddress), 32'(isD ? t_da : t_fa));
          chk("mem_size", 32'(memDataSize), 32'(isD ? t_dsz : 2'b11));
          chk("mem_rw", 32'(memReadWrite), 32'(isD ? t_drw : 1'b0));
          if (isD && t_drw) chk("mem_wdata", memDataIn, t_dwd);
        end
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("done_cycle", 32'(c), 32'(exp_c));
    chk("done_port", 32'({dDone, ifDone}), isD ? 32'd2 : 32'd1);
    chk("error", 32'(isD ? dError : ifError), 32'(ferr));
    chk("busy_done", 32'(busy), 32'd1);
    if (!ferr) begin
      if (!isD) exp_if = ref_read(t_fa, 4);
      else if (!t_drw) exp_d = ref_read(t_da, nbytes(t_dsz));
      else for (int i = 0; i < nbytes(t_dsz); i++) ref_mem[9'(int'(t_da) + i)] = t_dwd[8*i +: 8];
    end
    chk("ifData", ifData, exp_if);
    chk("dDataOut", dDataOut, exp_d);
`ifdef ARB_ROUND_ROBIN_EN
    rr_last = isD;
`endif
    if (isD) dReq = 1'b0;
    else     ifReq = 1'b0;
  endtask

  // Issue fetch and/or data requests at an IDLE negedge and check both completions.
  task automatic txn(input bit useF, input bit useD);
    bit first_d;
    ram_lat    = t_lat;
    ram_stall  = t_stall;
    ifAddress  = t_fa;
    dAddress   = t_da;
    dDataSize  = t_dsz;
    dReadWrite = t_drw;
    dDataIn    = t_dwd;
    ifReq      = useF;
    dReq       = useD;
    if (useF && useD) begin
`ifdef ARB_ROUND_ROBIN_EN
      first_d = !rr_last;
`else
      first_d = 1'b1;
`endif
      serve(first_d, 0);
      serve(!first_d, 1);
    end else begin
      serve(useD, 0);
    end
    @(negedge Clk);
    chk("idle_after", 32'({busy, ifDone, dDone, memFuncActive}), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
    ref_mem[0] = 8'h21; ref_mem[1] = 8'h08; ref_mem[2]  = 8'h00; ref_mem[3]  = 8'h00;
    ref_mem[4] = 8'h21; ref_mem[5] = 8'h10; ref_mem[6]  = 8'h21; ref_mem[7]  = 8'h00;
    ref_mem[8] = 8'h0F; ref_mem[9] = 8'h00; ref_mem[10] = 8'h23; ref_mem[11] = 8'h24;
    exp_if = '0;
    exp_d  = '0;
`ifdef ARB_ROUND_ROBIN_EN
    rr_last = 1'b0;
`endif
    Reset = 1'b1; ifReq = 1'b0; dReq = 1'b0; dReadWrite = 1'b0;
    ifAddress = '0; dAddress = '0; dDataIn = '0; dDataSize = '0;
    repeat (3) @(negedge Clk);

    // Reset state
    chk("rst_active", 32'(memFuncActive), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'({ifDone, dDone, ifError, dError}), 32'd0);
    chk("rst_mem", 32'({memReadWrite, memAddress, memDataSize}), 32'd0);
    chk("rst_memdin", memDataIn, 32'd0);
    chk("rst_ifData", ifData, 32'd0);
    chk("rst_dDataOut", dDataOut, 32'd0);
    Reset = 1'b0;
    @(negedge Clk);

    // Fetch of the preloaded program word
    setv(9'd0, 9'd0, 2'b11, 1'b0, 32'h0, 0, 1'b0); txn(1'b1, 1'b0);
    chk("tp_fetch0", ifData, 32'h00000821);

    // Word write then reads of various sizes
    setv(9'd0, 9'd16, 2'b11, 1'b1, 32'hDEADBEEF, 1, 1'b0); txn(1'b0, 1'b1);
    setv(9'd0, 9'd16, 2'b11, 1'b0, 32'h0, 2, 1'b0); txn(1'b0, 1'b1);
    chk("tp_rd_word", dDataOut, 32'hDEADBEEF);
    setv(9'd0, 9'd16, 2'b01, 1'b0, 32'h0, 0, 1'b0); txn(1'b0, 1'b1);
    chk("tp_rd_half", dDataOut, 32'h0000BEEF);
    setv(9'd0, 9'd17, 2'b00, 1'b0, 32'h0, 0, 1'b0); txn(1'b0, 1'b1);
    chk("tp_rd_byte17", dDataOut, 32'h000000BE);
    setv(9'd0, 9'd18, 2'b00, 1'b0, 32'h0, 3, 1'b0); txn(1'b0, 1'b1);
    chk("tp_rd_byte18", dDataOut, 32'h000000AD);

    // Simultaneous requests
    setv(9'd4, 9'd8, 2'b11, 1'b0, 32'h0, 0, 1'b0); txn(1'b1, 1'b1);
    chk("tp_both_d", dDataOut, 32'h2423000F);
    chk("tp_both_if", ifData, 32'h00211021);

    // Rejected accesses: misaligned word, invalid size, misaligned half, misaligned fetch
    setv(9'd0, 9'd2, 2'b11, 1'b0, 32'h0, 0, 1'b0); txn(1'b0, 1'b1);
    setv(9'd0, 9'd0, 2'b10, 1'b1, 32'h12345678, 0, 1'b0); txn(1'b0, 1'b1);
    setv(9'd0, 9'd33, 2'b01, 1'b1, 32'h0000CAFE, 0, 1'b0); txn(1'b0, 1'b1);
    setv(9'd6, 9'd0, 2'b11, 1'b0, 32'h0, 0, 1'b0); txn(1'b1, 1'b0);
    chk("rej_keep_d", dDataOut, 32'h2423000F);

    // RAM stall: timeout on both ports
    setv(9'd0, 9'd0, 2'b11, 1'b0, 32'h0, 0, 1'b1); txn(1'b0, 1'b1);
    setv(9'd8, 9'd0, 2'b11, 1'b0, 32'h0, 0, 1'b1); txn(1'b1, 1'b0);
    chk("to_keep_if", ifData, 32'h00211021);

    // Randomized mix
    for (int k = 0; k < 40; k++) begin
      int mode;
      mode = $urandom_range(0, 2);
      t_fa = ($urandom_range(0, 7) == 0) ? 9'($urandom) : {7'($urandom), 2'b00};
      t_dsz = 2'($urandom_range(0, 3));
      t_da  = 9'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (t_dsz == 2'b11) t_da[1:0] = 2'b00;
        if (t_dsz == 2'b01) t_da[0] = 1'b0;
      end
      t_drw   = 1'($urandom);
      t_dwd   = $urandom;
      t_lat   = $urandom_range(0, 4);
      t_stall = 1'b0;
      txn(mode != 1, mode != 0);
    end

    // Reset in the middle of ACTIVE
    setv(9'd0, 9'd0, 2'b11, 1'b0, 32'h0, 0, 1'b1);
    ram_stall = 1'b1;
    dAddress = t_da; dDataSize = t_dsz; dReadWrite = 1'b0; dReq = 1'b1;
    repeat (3) @(negedge Clk);
    chk("mid_active", 32'(memFuncActive), 32'd1);
    Reset = 1'b1;
    dReq  = 1'b0;
    @(negedge Clk);
    chk("mid_rst_active", 32'(memFuncActive), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    Reset = 1'b0;
    ram_stall = 1'b0;
    exp_if = '0;
    exp_d  = '0;
`ifdef ARB_ROUND_ROBIN_EN
    rr_last = 1'b0;
`endif
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      chk("mid_rst_nodone", 32'({ifDone, dDone}), 32'd0);
    end
    chk("mid_rst_ifData", ifData, exp_if);
    chk("mid_rst_dData", dDataOut, exp_d);

    // Normal operation resumes after reset
    setv(9'd8, 9'd0, 2'b11, 1'b0, 32'h0, 1, 1'b0); txn(1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
